cordic_arbiter: RTL and testbench

//  Shares one ex_top CORDIC pipeline among NUM_REQ requesters; sits between requester valid/ready ports and pipeline 32-bit word ports.

---
 rtl/cordic_arbiter_pkg.sv | 22 ++
 rtl/cordic_tag_fifo.sv | 61 ++++++
 rtl/cordic_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cordic_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arbiter_pkg.sv
// Shared definitions for the CORDIC pipeline arbiter: sequencer states,
// default pipeline word width and a ceiling-log2 helper for sizing counters.
package cordic_arbiter_pkg;

    localparam int unsigned CORDIC_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StDrained = 2'd2
    } arb_state_e;

    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// Synchronous tag FIFO: remembers which requester owns each in-flight
// pipeline slot so in-order results can be routed back.
module cordic_tag_fifo import cordic_arbiter_pkg::*; #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = ceil_log2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? ceil_log2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 do_push, do_pop;

    assign full     = (count_q == CNT_WIDTH'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC pipeline among NUM_REQ requesters,
// with tag-based result routing and a drain sequencer.
// Optional build macro CORDIC_ARB_PRIO_EN: requester 0 always wins and the
// round-robin pointer rotates only among requesters 1..NUM_REQ-1.
module cordic_arbiter import cordic_arbiter_pkg::*; #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned REQ_ID_WIDTH = 2,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned DATA_WIDTH   = CORDIC_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         pipe_in_data,
    output logic                          pipe_in_valid,
    input  logic [DATA_WIDTH-1:0]         pipe_out_data,
    input  logic                          pipe_out_valid,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    input  logic                          drain_req,
    output logic                          drain_done,
    output logic                          err_orphan
);

    localparam int unsigned CntWidth = ceil_log2(MAX_INFLIGHT + 1);

    arb_state_e              state_q, state_d;
    logic [REQ_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_ID_WIDTH-1:0] scan_idx;
    logic [REQ_ID_WIDTH-1:0] grant_id;
    logic                    grant_any;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [NUM_REQ-1:0]      rr_cand;
    logic                    prio_hit;
    logic                    issue_ok;

    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [REQ_ID_WIDTH-1:0] pop_tag;
    logic [CntWidth-1:0]     inflight;

    logic                    pipe_in_valid_q;
    logic [DATA_WIDTH-1:0]   pipe_in_data_q;
    logic [NUM_REQ-1:0]      resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    err_orphan_q;

`ifdef CORDIC_ARB_PRIO_EN
    assign rr_cand  = req_valid & ~NUM_REQ'(1);
    assign prio_hit = req_valid[0];
`else
    assign rr_cand  = req_valid;
    assign prio_hit = 1'b0;
`endif

    // Full FIFO blocks issue even if a result pops in the same cycle.
    assign issue_ok = !reset && (state_q == StRun) && !drain_req && !fifo_full;
    assign fifo_pop = pipe_out_valid && !fifo_empty;

    // Grant: first candidate scanning upward from rr_ptr, plus the selected command word.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        sel_data  = '0;
        if (issue_ok) begin
            if (prio_hit) begin
                grant_any = 1'b1;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    scan_idx = REQ_ID_WIDTH'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
                    if (!grant_any && rr_cand[scan_idx]) begin
                        grant_any = 1'b1;
                        grant_id  = scan_idx;
                    end
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (REQ_ID_WIDTH'(i) == grant_id) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    end

    // Pointer advance past the winner; a priority grant leaves it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
`ifdef CORDIC_ARB_PRIO_EN
            if (grant_id != '0) begin
                rr_ptr_d = (grant_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? REQ_ID_WIDTH'(1)
                                                                    : grant_id + REQ_ID_WIDTH'(1);
            end
`else
            rr_ptr_d = (grant_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                : grant_id + REQ_ID_WIDTH'(1);
`endif
        end
    end

    // Drain sequencer next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (drain_req) state_d = StDrain;
            end
            StDrain: begin
                if (!drain_req) begin
                    state_d = StRun;
                end else if (inflight == '0 && resp_valid_q == '0) begin
                    state_d = StDrained;
                end
            end
            StDrained: begin
                if (!drain_req) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StRun;
            rr_ptr_q        <= '0;
            pipe_in_valid_q <= 1'b0;
            pipe_in_data_q  <= '0;
            resp_valid_q    <= '0;
            resp_data_q     <= '0;
            err_orphan_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            pipe_in_valid_q <= grant_any;
            if (grant_any) begin
                pipe_in_data_q <= sel_data;
            end
            resp_valid_q <= fifo_pop ? (NUM_REQ'(1) << pop_tag) : '0;
            if (fifo_pop) begin
                resp_data_q <= pipe_out_data;
            end
            // A result with no owner is dropped and flagged until reset.
            if (pipe_out_valid && fifo_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    cordic_tag_fifo #(
        .WIDTH     (REQ_ID_WIDTH),
        .DEPTH     (MAX_INFLIGHT),
        .CNT_WIDTH (CntWidth)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_any),
        .push_data (grant_id),
        .pop       (fifo_pop),
        .pop_data  (pop_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (inflight)
    );

    assign pipe_in_valid = pipe_in_valid_q;
    assign pipe_in_data  = pipe_in_data_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign err_orphan    = err_orphan_q;
    assign drain_done    = (state_q == StDrained);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: directed scenarios plus a random
// phase, all compared against a queue-based reference model each cycle.
module tb_cordic_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int MAXF = 4;
    localparam int DW   = 32;
    localparam logic [DW-1:0] XK = 32'h5A5A_0F0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   pipe_in_data;
    logic            pipe_in_valid;
    logic [DW-1:0]   pipe_out_data;
    logic            pipe_out_valid;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            drain_req;
    logic            drain_done;
    logic            err_orphan;

    cordic_arbiter #(
        .NUM_REQ      (N),
        .REQ_ID_WIDTH (IDW),
        .MAX_INFLIGHT (MAXF),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .pipe_in_data   (pipe_in_data),
        .pipe_in_valid  (pipe_in_valid),
        .pipe_out_data  (pipe_out_data),
        .pipe_out_valid (pipe_out_valid),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .err_orphan     (err_orphan)
    );

    int n_chk = 0;
    int n_err = 0;
    int step_no = 0;

    // Reference model: mode 0 running, 1 draining, 2 drained.
    int            m_rr;
    int            m_mode;
    int            m_tags[$];
    logic          m_in_valid;
    logic [DW-1:0] m_in_data;
    logic [N-1:0]  m_resp;
    logic [DW-1:0] m_resp_data;
    logic          m_orphan;

    // Pipeline stand-in: fixed delay line, result = command ^ XK.
    int            lat;
    logic          dl_v [8];
    logic [DW-1:0] dl_d [8];

    logic [N-1:0]  obs_ready, obs_resp;
    logic [DW-1:0] obs_resp_data;
    logic          obs_done, obs_in_valid, obs_orphan;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_mode = 0;
        m_tags.delete();
        m_in_valid = 1'b0;
        m_in_data = '0;
        m_resp = '0;
        m_resp_data = '0;
        m_orphan = 1'b0;
    endtask

    function automatic logic [N-1:0] model_grant();
        if (reset || m_mode != 0 || drain_req || m_tags.size() >= MAXF) return '0;
`ifdef CORDIC_ARB_PRIO_EN
        if (req_valid[0]) return N'(1);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (i != 0 && req_valid[i]) return N'(1) << i;
        end
`else
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (req_valid[i]) return N'(1) << i;
        end
`endif
        return '0;
    endfunction

    // One clock: check outputs at the falling edge, advance model, then the pipeline.
    task automatic step();
        logic [N-1:0]  g;
        logic [N-1:0]  nresp;
        logic          cap_v;
        logic [DW-1:0] cap_d;
        int            gi;
        int            sz;
        @(negedge clk);
        g = model_grant();
        obs_ready     = req_ready;
        obs_resp      = resp_valid;
        obs_resp_data = resp_data;
        obs_done      = drain_done;
        obs_in_valid  = pipe_in_valid;
        obs_orphan    = err_orphan;
        chk("req_ready", 32'(req_ready), 32'(g));
        chk("pipe_in_valid", 32'(pipe_in_valid), 32'(m_in_valid));
        if (m_in_valid) chk("pipe_in_data", pipe_in_data, m_in_data);
        chk("resp_valid", 32'(resp_valid), 32'(m_resp));
        if (m_resp != '0) chk("resp_data", resp_data, m_resp_data);
        chk("drain_done", 32'(drain_done), 32'(m_mode == 2));
        chk("err_orphan", 32'(err_orphan), 32'(m_orphan));
        cap_v = pipe_in_valid;
        cap_d = pipe_in_data;
        if (reset) begin
            model_reset();
        end else begin
            sz = m_tags.size();
            case (m_mode)
                0: if (drain_req) m_mode = 1;
                1: if (!drain_req) m_mode = 0;
                   else if (sz == 0 && m_resp == '0) m_mode = 2;
                default: if (!drain_req) m_mode = 0;
            endcase
            nresp = '0;
            if (pipe_out_valid) begin
                if (m_tags.size() > 0) begin
                    nresp = N'(1) << m_tags.pop_front();
                    m_resp_data = pipe_out_data;
                end else begin
                    m_orphan = 1'b1;
                end
            end
            m_resp = nresp;
            m_in_valid = (g != '0);
            if (g != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (g[i]) gi = i;
                m_tags.push_back(gi);
                m_in_data = req_data[gi*DW +: DW];
`ifdef CORDIC_ARB_PRIO_EN
                if (gi != 0) m_rr = (gi == N - 1) ? 1 : gi + 1;
`else
                m_rr = (gi + 1) % N;
`endif
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                dl_v[i] = 1'b0;
                dl_d[i] = '0;
            end
        end else begin
            for (int i = 7; i > 0; i--) begin
                dl_v[i] = dl_v[i-1];
                dl_d[i] = dl_d[i-1];
            end
            dl_v[0] = cap_v;
            dl_d[0] = cap_d ^ XK;
        end
        pipe_out_valid = dl_v[lat-1];
        pipe_out_data  = dl_d[lat-1];
        step_no++;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [13:0] pat;
        logic [7:0]  order;
        int          last_resp;
        int          rise;

        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        drain_req = 1'b0;
        pipe_out_valid = 1'b0;
        pipe_out_data = '0;
        lat = 2;
        for (int i = 0; i < 8; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();
        chk("reset_resp", 32'(obs_resp), 32'(0));
        chk("reset_in_valid", 32'(obs_in_valid), 32'(0));
        reset = 1'b0;

        // All requesters valid from reset: grants rotate 0,1,2,3,0 with no issue gaps.
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            step();
`ifndef CORDIC_ARB_PRIO_EN
            chk("t1_grant", 32'(obs_ready), 32'(1 << (k % 4)));
`endif
            if (k > 0) chk("t1_issue", 32'(obs_in_valid), 32'(1));
        end
        idle(10);

        // Single streamer, 6 cycles grant-to-result: 4 issues, 3 stalled, then one per result.
        lat = 5;
        pat = 14'b000_1111_000_1111;
        req_valid = 4'b0001;
        for (int k = 0; k < 14; k++) begin
            rand_data();
            step();
            chk("t2_stall", 32'(obs_ready[0]), 32'(pat[k]));
        end
        idle(12);

        // Requesters 1 and 3: results return to their owners in order.
        req_data[1*DW +: DW] = 32'h1111_0001;
        req_data[3*DW +: DW] = 32'h3333_0003;
        req_valid = 4'b1010;
        step();
        step();
        req_valid = '0;
        order = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obs_resp != '0) order = {order[3:0], 4'(obs_resp)};
            if (obs_resp == 4'b0010) chk("t3_data1", obs_resp_data, 32'h1111_0001 ^ XK);
            if (obs_resp == 4'b1000) chk("t3_data3", obs_resp_data, 32'h3333_0003 ^ XK);
        end
        chk("t3_order", 32'(order), 32'h28);
        idle(4);

        // Drain with three in flight, then release.
        req_valid = '1;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            step();
        end
        drain_req = 1'b1;
        last_resp = -1;
        rise = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            chk("t4_no_grant", 32'(obs_ready), 32'(0));
            if (obs_resp != '0) last_resp = step_no;
            if (obs_done) begin
                rise = step_no;
                break;
            end
        end
        chk("t4_done_seen", 32'(obs_done), 32'(1));
        chk("t4_done_gap", 32'(rise - last_resp), 32'(2));
        drain_req = 1'b0;
        step();
        chk("t4_still_drained", 32'(obs_ready), 32'(0));
        step();
`ifdef CORDIC_ARB_PRIO_EN
        chk("t4_resume", 32'(obs_ready), 32'(4'b0001));
`else
        chk("t4_resume", 32'(obs_ready), 32'(4'b1000));
`endif
        idle(12);

        // Orphan result with nothing in flight.
        pipe_out_valid = 1'b1;
        pipe_out_data = $urandom;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_orphan", 32'(obs_orphan), 32'(1));
            chk("t5_no_resp", 32'(obs_resp), 32'(0));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t5_cleared", 32'(obs_orphan), 32'(0));

`ifdef CORDIC_ARB_PRIO_EN
        // Requester 0 dominates while valid.
        lat = 2;
        req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            step();
            chk("t6_prio", 32'(obs_ready), 32'(4'b0001));
        end
        req_valid = 4'b0100;
        step();
        chk("t6_fallback", 32'(obs_ready), 32'(4'b0100));
        idle(10);
        lat = 5;
`endif

        // Random traffic with occasional drains and one mid-run reset.
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            rand_data();
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            reset = (k == 200 || k == 201);
            step();
        end
        reset = 1'b0;
        drain_req = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
